// File: rtl/seq_multiplier_if.sv
// Handshake bundle for seq_multiplier: request/operands in, status/product out.
// The master side issues operations; the multiplier core sits on the slave side.
interface seq_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   p;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, p
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, p
    );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: magnitudes are multiplied one multiplier bit per
// clock, then the product sign is applied in a final cycle and held on p.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_multiplier_if.slave    bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [PW-1:0]     mcand_r, mcand_s;
    logic [WIDTH-1:0]  mult_r, mult_s;
    logic [PW-1:0]     acc_r, acc_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic              mode_r, mode_s;
    logic              sign_r, sign_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [PW-1:0]     p_r, p_s;

    // Unsigned magnitude of an operand; WIDTH bits suffice even for the most negative value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH-1:0] m;
        if (sgn && v[WIDTH-1]) begin
            m = ~v + WIDTH'(1);
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Two's-complement negation of the accumulated product when the result is negative.
    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic neg);
        logic [PW-1:0] r;
        if (neg) begin
            r = ~v + PW'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Next-state and next-register computation for the whole datapath.
    always_comb begin
        state_s = state_r;
        mcand_s = mcand_r;
        mult_s  = mult_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        mode_s  = mode_r;
        sign_s  = sign_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        p_s     = p_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_CALC;
                    mode_s  = bus.is_signed;
                    mcand_s = PW'(magnitude(bus.a, bus.is_signed));
                    mult_s  = magnitude(bus.b, bus.is_signed);
                    sign_s  = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_s   = '0;
                    cnt_s   = '0;
                    busy_s  = 1'b1;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            ST_CALC: begin
                if (mult_r[0]) begin
                    acc_s = acc_r + mcand_r;
                end else begin
                    acc_s = acc_r;
                end
                // Multiplicand walks left while the multiplier walks right, so bit 0 is always current.
                mcand_s = mcand_r << 1;
                mult_s  = mult_r >> 1;
                cnt_s   = cnt_r + CW'(1);
                if (cnt_r == CW'(WIDTH - 1)) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_FIN: begin
                p_s     = apply_sign(acc_r, mode_r & sign_r);
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            mcand_r <= '0;
            mult_r  <= '0;
            acc_r   <= '0;
            cnt_r   <= '0;
            mode_r  <= 1'b0;
            sign_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            p_r     <= '0;
        end else begin
            state_r <= state_s;
            mcand_r <= mcand_s;
            mult_r  <= mult_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            mode_r  <= mode_s;
            sign_r  <= sign_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            p_r     <= p_s;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.p    = p_r;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_multiplier;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    seq_multiplier_if #(.WIDTH(4)) bus4 ();
    seq_multiplier_if #(.WIDTH(8)) bus8 ();

    seq_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    seq_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one WIDTH=4 operation and wait (bounded) for done; lat counts edges after acceptance.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sgn,
                        output logic [7:0] prod, output int lat);
        bus4.start     = 1'b1;
        bus4.a         = a;
        bus4.b         = b;
        bus4.is_signed = sgn;
        tick();
        bus4.start = 1'b0;
        lat = 0;
        while (!bus4.done && lat < 20) begin
            tick();
            lat++;
        end
        prod = bus4.p;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                        output logic [15:0] prod, output int lat);
        bus8.start     = 1'b1;
        bus8.a         = a;
        bus8.b         = b;
        bus8.is_signed = sgn;
        tick();
        bus8.start = 1'b0;
        lat = 0;
        while (!bus8.done && lat < 30) begin
            tick();
            lat++;
        end
        prod = bus8.p;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed running, required finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0]  prod4;
        logic [15:0] prod8;
        int          lat;
        int          dones;
        int          exp_i;
        int          ia;
        int          ib;
        logic [3:0]  ta;
        logic [3:0]  tb;
        logic        held_ok;
        logic        busy_ok;

        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        bus4.start = 1'b0; bus4.a = 4'd0; bus4.b = 4'd0; bus4.is_signed = 1'b0;
        bus8.start = 1'b0; bus8.a = 8'd0; bus8.b = 8'd0; bus8.is_signed = 1'b0;
        tick();
        tick();
        check("reset_busy4", 32'(bus4.busy), 32'd0);
        check("reset_done4", 32'(bus4.done), 32'd0);
        check("reset_p4",    32'(bus4.p),    32'd0);
        check("reset_p8",    32'(bus8.p),    32'd0);
        rst_n = 1'b1;
        tick();

        // Busy must rise at the accepting edge.
        bus4.start = 1'b1; bus4.a = 4'd15; bus4.b = 4'd15; bus4.is_signed = 1'b0;
        tick();
        bus4.start = 1'b0;
        check("busy_after_accept", 32'(bus4.busy), 32'd1);
        repeat (6) tick();

        run4(4'd15, 4'd15, 1'b0, prod4, lat);
        check("u_15x15", 32'(prod4), 32'd225);
        check("u_15x15_lat", 32'(lat), 32'd5);
        check("u_15x15_busy_in_done", 32'(bus4.busy), 32'd0);
        tick();
        check("done_one_cycle", 32'(bus4.done), 32'd0);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run4(4'(i), 4'(j), 1'b0, prod4, lat);
                check($sformatf("u_%0dx%0d", i, j), 32'(prod4), 32'(i * j));
                check($sformatf("u_%0dx%0d_lat", i, j), 32'(lat), 32'd5);
            end
        end

        run4(4'h8, 4'h8, 1'b1, prod4, lat);
        check("s_m8xm8", 32'(prod4), 32'h40);
        run4(4'h8, 4'h7, 1'b1, prod4, lat);
        check("s_m8x7", 32'(prod4), 32'hC8);
        run4(4'hF, 4'hF, 1'b1, prod4, lat);
        check("s_m1xm1", 32'(prod4), 32'h01);
        run4(4'h7, 4'hF, 1'b1, prod4, lat);
        check("s_7xm1", 32'(prod4), 32'hF9);
        run4(4'h0, 4'h8, 1'b1, prod4, lat);
        check("s_0xm8", 32'(prod4), 32'h00);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                ta = 4'(i);
                tb = 4'(j);
                ia = $signed(ta);
                ib = $signed(tb);
                exp_i = ia * ib;
                run4(ta, tb, 1'b1, prod4, lat);
                check($sformatf("s_%0dx%0d", ia, ib), 32'(prod4), 32'(exp_i[7:0]));
            end
        end
        tick();

        // Start pulsed during CALC must not disturb the running operation.
        bus4.start = 1'b1; bus4.a = 4'd3; bus4.b = 4'd5; bus4.is_signed = 1'b0;
        tick();
        bus4.start = 1'b0;
        tick();
        bus4.start = 1'b1; bus4.a = 4'd7; bus4.b = 4'd7; bus4.is_signed = 1'b1;
        tick();
        bus4.start = 1'b0;
        dones = 0;
        prod4 = 8'd0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus4.done) begin
                dones++;
                prod4 = bus4.p;
            end
        end
        check("ignored_start_result", 32'(prod4), 32'd15);
        check("ignored_start_dones", 32'(dones), 32'd1);

        // Back-to-back: second start issued in the first done cycle.
        run4(4'd15, 4'd15, 1'b0, prod4, lat);
        check("b2b_first", 32'(prod4), 32'd225);
        bus4.start = 1'b1; bus4.a = 4'd2; bus4.b = 4'd3; bus4.is_signed = 1'b0;
        tick();
        bus4.start = 1'b0;
        busy_ok = bus4.busy;
        lat = 1;
        held_ok = 1'b1;
        while (!bus4.done && lat < 20) begin
            if (bus4.p !== 8'd225) held_ok = 1'b0;
            tick();
            lat++;
        end
        check("b2b_accepted_busy", 32'(busy_ok), 32'd1);
        check("b2b_gap", 32'(lat), 32'd6);
        check("b2b_p_held", 32'(held_ok), 32'd1);
        check("b2b_second", 32'(bus4.p), 32'd6);
        tick();

        // Reset during iteration 2 aborts the operation.
        bus4.start = 1'b1; bus4.a = 4'd9; bus4.b = 4'd9; bus4.is_signed = 1'b0;
        tick();
        bus4.start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", 32'(bus4.busy), 32'd0);
        check("midrst_p", 32'(bus4.p), 32'd0);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus4.done) dones++;
            tick();
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        run4(4'd3, 4'd5, 1'b0, prod4, lat);
        check("midrst_then_3x5", 32'(prod4), 32'd15);
        tick();

        run8(8'd255, 8'd255, 1'b0, prod8, lat);
        check("w8_u_255x255", 32'(prod8), 32'd65025);
        check("w8_u_lat", 32'(lat), 32'd9);
        run8(8'h80, 8'h80, 1'b1, prod8, lat);
        check("w8_s_m128xm128", 32'(prod8), 32'd16384);
        run8(8'h80, 8'h7F, 1'b1, prod8, lat);
        check("w8_s_m128x127", 32'(prod8), 32'hC080);
        run8(8'd13, 8'd11, 1'b0, prod8, lat);
        check("w8_u_13x11", 32'(prod8), 32'd143);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
